// File: rtl/demux_1x8_deser.sv
// Serial-to-parallel 1:8 demux: collects eight accepted bits into a byte and
// offers it on a valid/ready output, with one byte of extra hold space.
//
// state | meaning
// IDLE  | sel = 0, no partial byte held
// FILL  | 1..7 bits held in the assembly buffer
// FULL  | complete byte waiting in the assembly buffer, output register occupied
module demux_1x8_deser #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       abort,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] sel,
  output logic [7:0] byte_count
);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t     state, state_nxt;
  logic [7:0] asm_buf, asm_nxt, filled;
  logic [7:0] od_nxt;
  logic [2:0] sel_nxt, pos;
  logic       ov_nxt, xfer, deliver;

  assign in_ready = (state != FULL);
  assign xfer     = in_valid & in_ready & ~abort;
  assign deliver  = out_valid & out_ready;
  assign pos      = MSB_FIRST ? (3'd7 - sel) : sel;

  always_comb begin
    filled      = asm_buf;
    filled[pos] = in_bit;
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    asm_nxt   = asm_buf;
    od_nxt    = out_data;
    ov_nxt    = out_valid & ~out_ready;
    if (abort) begin
      // The output side is untouched: a same-cycle delivery still completes.
      state_nxt = IDLE;
      sel_nxt   = 3'd0;
      asm_nxt   = 8'h00;
    end else if (state == FULL) begin
      if (out_ready) begin
        od_nxt    = asm_buf;
        ov_nxt    = 1'b1;
        asm_nxt   = 8'h00;
        state_nxt = IDLE;
      end
    end else if (xfer) begin
      sel_nxt = sel + 3'd1;
      if (sel == 3'd7) begin
        if (!out_valid || out_ready) begin
          od_nxt    = filled;
          ov_nxt    = 1'b1;
          asm_nxt   = 8'h00;
          state_nxt = IDLE;
        end else begin
          asm_nxt   = filled;
          state_nxt = FULL;
        end
      end else begin
        asm_nxt   = filled;
        state_nxt = FILL;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Buffer is cleared whenever a byte leaves it, so unwritten bits read 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel        <= 3'd0;
      asm_buf    <= 8'h00;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      byte_count <= 8'h00;
    end else begin
      sel        <= sel_nxt;
      asm_buf    <= asm_nxt;
      out_data   <= od_nxt;
      out_valid  <= ov_nxt;
      if (deliver) byte_count <= byte_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_demux_1x8_deser.sv
// Bench for demux_1x8_deser: both bit orders side by side against a
// queue-based byte model, directed scenarios followed by random traffic.
module tb_demux_1x8_deser;

  logic       clk = 1'b0;
  logic       reset, in_bit, in_valid, abort, out_ready;
  logic       in_ready0, in_ready1, ov0, ov1;
  logic [7:0] od0, od1, bc0, bc1;
  logic [2:0] sel0, sel1;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: partial bits in arrival order, byte values kept in LSB-first form.
  bit         m_bits[$];
  bit         m_full, m_ov;
  logic [7:0] m_held, m_od, m_cnt;

  always #5 clk = ~clk;

  demux_1x8_deser #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready0), .abort(abort), .out_data(od0), .out_valid(ov0),
    .out_ready(out_ready), .sel(sel0), .byte_count(bc0));

  demux_1x8_deser #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready1), .abort(abort), .out_data(od1), .out_valid(ov1),
    .out_ready(out_ready), .sel(sel1), .byte_count(bc1));

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_full = 1'b0;
    m_ov   = 1'b0;
    m_held = 8'h00;
    m_od   = 8'h00;
    m_cnt  = 8'h00;
  endtask

  task automatic model_step(input bit b, input bit v, input bit ordy, input bit ab);
    bit         ov_pre;
    logic [7:0] val;
    ov_pre = m_ov;
    if (m_ov && ordy) begin
      m_cnt = m_cnt + 8'd1;
      m_ov  = 1'b0;
    end
    if (ab) begin
      m_bits.delete();
      m_full = 1'b0;
    end else if (m_full) begin
      if (ordy) begin
        m_od   = m_held;
        m_ov   = 1'b1;
        m_full = 1'b0;
      end
    end else if (v) begin
      m_bits.push_back(b);
      if (m_bits.size() == 8) begin
        val = 8'h00;
        for (int k = 0; k < 8; k++) val = val + (8'(m_bits[k]) << k);
        m_bits.delete();
        if (!ov_pre || ordy) begin
          m_od = val;
          m_ov = 1'b1;
        end else begin
          m_held = val;
          m_full = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, " in_ready0"}, {7'b0, in_ready0}, {7'b0, !m_full});
    chk({ctx, " in_ready1"}, {7'b0, in_ready1}, {7'b0, !m_full});
    chk({ctx, " sel0"}, {5'b0, sel0}, 8'(m_bits.size()));
    chk({ctx, " sel1"}, {5'b0, sel1}, 8'(m_bits.size()));
    chk({ctx, " out_valid0"}, {7'b0, ov0}, {7'b0, m_ov});
    chk({ctx, " out_valid1"}, {7'b0, ov1}, {7'b0, m_ov});
    chk({ctx, " out_data0"}, od0, m_od);
    chk({ctx, " out_data1"}, od1, rev8(m_od));
    chk({ctx, " byte_count0"}, bc0, m_cnt);
    chk({ctx, " byte_count1"}, bc1, m_cnt);
  endtask

  task automatic cycle(input bit b, input bit v, input bit ordy, input bit ab);
    in_bit    = b;
    in_valid  = v;
    out_ready = ordy;
    abort     = ab;
    @(posedge clk);
    model_step(b, v, ordy, ab);
    #1;
    check_all("cyc");
  endtask

  task automatic send_byte_lsb(input logic [7:0] v, input bit ordy);
    logic [7:0] t;
    t = v;
    for (int k = 0; k < 8; k++) cycle(t[k], 1'b1, ordy, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    reset = 1'b1; in_bit = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    do_reset();
    check_all("post_reset");

    // Reference stream 1,0,1,1,0,0,1,0
    pat = 8'b0100_1101;
    for (int k = 0; k < 8; k++) cycle(pat[k], 1'b1, 1'b1, 1'b0);
    chk("ref_lsb_data", od0, 8'h4D);
    chk("ref_msb_data", od1, 8'hB2);
    chk("ref_valid", {7'b0, ov0}, 8'h01);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ref_valid_drop", {7'b0, ov0}, 8'h00);
    chk("ref_count", bc0, 8'h01);

    // Back-pressure: second byte held in FULL until consumer is ready
    do_reset();
    send_byte_lsb(8'hFF, 1'b0);
    send_byte_lsb(8'h0F, 1'b0);
    chk("full_in_ready", {7'b0, in_ready0}, 8'h00);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("full_stable", od0, 8'hFF);
    chk("full_still_blocked", {7'b0, in_ready0}, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("full_release_data", od0, 8'h0F);
    chk("full_release_ready", {7'b0, in_ready0}, 8'h01);
    chk("full_release_count", bc0, 8'h01);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Abort in the same cycle as a transfer
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
    chk("abort_pre_sel", {5'b0, sel0}, 8'h03);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    chk("abort_sel", {5'b0, sel0}, 8'h00);
    send_byte_lsb(8'hA5, 1'b1);
    chk("abort_then_a5", od0, 8'hA5);

    // Abort while FULL discards the held byte
    send_byte_lsb(8'h3C, 1'b0);
    send_byte_lsb(8'hC3, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("abort_full_ready", {7'b0, in_ready0}, 8'h01);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset between edges with out_valid high at sel = 5
    send_byte_lsb(8'h81, 1'b0);
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("async_pre_sel", {5'b0, sel0}, 8'h05);
    chk("async_pre_valid", {7'b0, ov0}, 8'h01);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    chk("first_after_reset", {5'b0, sel0}, 8'h01);

    // Random traffic with occasional aborts
    for (int n = 0; n < 3000; n++)
      cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);

    // 256 back-to-back bytes: byte_count must wrap to 0 with no bubbles
    do_reset();
    for (int n = 0; n < 2048; n++) begin
      cycle(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
      if (n % 8 == 7) chk("b2b_valid", {7'b0, ov0}, 8'h01);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("b2b_wrap", bc0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1x8_deser.md
DEMUX_1X8_DESER -- requirements
Module: demux_1x8_deser

Interface
REQ-001 Parameter MSB_FIRST, default 0, bit order: 0 = first accepted bit lands in out_data[0]; 1 = first bit lands in out_data[7].
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_bit  input  1  serial data bit.
REQ-005 in_valid  input  1  in_bit valid this cycle.
REQ-006 in_ready  output  1  block accepts in_bit this cycle; a transfer occurs when in_valid & in_ready.
REQ-007 abort  input  1  synchronous discard of the partial byte.
REQ-008 out_data  output  8  assembled byte.
REQ-009 out_valid  output  1  out_data holds an undelivered byte.
REQ-010 out_ready  input  1  consumer accepts out_data; delivery occurs when out_valid & out_ready.
REQ-011 sel  output  3  current demux slot 0..7, sel[2] = MSB, slot k = k-th bit of the byte.
REQ-012 byte_count  output  8  count of delivered bytes, wraps 255 -> 0.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE (sel = 0, no partial byte), FILL (1..7 bits held), FULL (complete byte held in the assembly buffer, output register occupied).
REQ-014 in_ready SHALL be 1 in IDLE and FILL and 0 in FULL, combinationally from state only.
REQ-015 On each transfer, in_bit SHALL be written to assembly-buffer position sel (MSB_FIRST = 0) or 7 - sel (MSB_FIRST = 1), and sel SHALL increment by 1.
REQ-016 Transfer with sel = 0..6: IDLE -> FILL, or FILL -> FILL.
REQ-017 Transfer with sel = 7 while out_valid = 0 or out_ready = 1: the complete byte, including the current bit, SHALL load into out_data; out_valid SHALL be 1 next cycle; sel SHALL wrap to 0; state -> IDLE.
REQ-018 Transfer with sel = 7 while out_valid = 1 and out_ready = 0: the byte SHALL be held in the assembly buffer, sel SHALL wrap to 0, state -> FULL.
REQ-019 In FULL, when out_ready = 1, the held byte SHALL move to out_data and out_valid SHALL stay 1; state -> IDLE.
REQ-020 A delivery with no same-cycle load SHALL clear out_valid next cycle.
REQ-021 out_data SHALL remain stable while out_valid = 1 and out_ready = 0.
REQ-022 byte_count SHALL increment by 1 on every delivery, modulo 256.
REQ-023 Latency: the 8th bit accepted at edge N SHALL appear on out_data with out_valid = 1 immediately after edge N, unless the byte is held per REQ-018.
REQ-024 Throughput: with out_ready held at 1, one byte per 8 transfers with no bubble cycles.
REQ-025 abort = 1 SHALL set sel to 0, discard the assembly buffer, and set state to IDLE.
REQ-026 This applies in any state, including FULL, where the held byte is lost.
REQ-027 abort SHALL take priority over a same-cycle transfer, which is ignored.
REQ-028 abort SHALL NOT affect out_data, out_valid or byte_count; a same-cycle delivery still completes.
REQ-029 Assembly-buffer bits not yet written SHALL read 0 internally.

Reset
REQ-030 reset = 1 SHALL immediately, without waiting for clk, force: state IDLE, sel = 0, in_ready = 1, assembly buffer = 0, out_data = 8'h00, out_valid = 0, byte_count = 0.
REQ-031 Reset asserted mid-byte or in FULL SHALL discard all data.
REQ-032 The first transfer after reset deasserts SHALL land in slot 0.

Verification
REQ-033 MSB_FIRST = 0, out_ready = 1, bits 1,0,1,1,0,0,1,0 on consecutive cycles -> out_data = 8'h4D with out_valid high for 1 cycle after the 8th edge; byte_count = 1.
REQ-034 MSB_FIRST = 1, same bit stream -> out_data = 8'hB2.
REQ-035 out_ready = 0; stream 8'hFF then 8'h0F -> 1st byte shown and stable, in_ready drops after the 16th bit (FULL), stays 0; out_ready = 1 for 1 cycle -> out_data = 8'h0F, in_ready = 1, byte_count = 1.
REQ-036 3 bits accepted (sel = 3), then abort together with in_valid -> sel = 0, bit ignored; next 8 bits of 8'hA5 -> out_data = 8'hA5.
REQ-037 reset asserted between clock edges at sel = 5 with out_valid = 1 -> all outputs return to reset values at once, with no clock edge.
REQ-038 256 back-to-back bytes delivered -> byte_count wraps to 0; no bubbles between bytes.
